// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO push arbiter and the FIFO it feeds.
package fifo_arb_pkg;

  typedef enum logic [1:0] {
    OPEN     = 2'b00,
    THROTTLE = 2'b01
  } arb_state_e;

  localparam int STAT_W     = 16;
  localparam int FIFO_DEPTH = 32;

endpackage

// File: rtl/fifo_push_arb_rr_arbiter.sv
// Combinational round-robin picker: first active request at or after ptr,
// wrapping modulo NREQ. The pointer register lives in the parent.
module rr_arbiter #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic             enable,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  gnt,
  output logic [IDX_W-1:0] gnt_idx
);

  logic             found;
  logic [IDX_W-1:0] idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    idx     = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % NREQ);
      if (enable && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_idx  = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_push_arb.sv
// Round-robin push arbiter, pop gate and watermark throttle for the shared FIFO.
// Optional per-port grant counters are built when FIFO_PUSH_ARB_STATS_EN is defined.
module fifo_push_arb
  import fifo_arb_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int WIDTH     = 8,
  parameter int DEPTH     = FIFO_DEPTH,
  parameter int LOG2DEPTH = 5,
  parameter int HI_WM     = 28,
  parameter int LO_WM     = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*WIDTH-1:0]  req_data,
  output logic [NREQ-1:0]        gnt,
  input  logic                   pop_req,
  output logic                   pop_ack,
  output logic                   fifo_push,
  output logic                   fifo_pop,
  output logic [WIDTH-1:0]       fifo_datain,
  output logic [LOG2DEPTH:0]     occ,
`ifdef FIFO_PUSH_ARB_STATS_EN
  output logic [NREQ*STAT_W-1:0] grant_cnt,
`endif
  output logic                   throttle
);

  localparam int OCC_W = LOG2DEPTH + 1;
  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [OCC_W-1:0] DEPTH_V = OCC_W'(DEPTH);
  localparam logic [OCC_W-1:0] HI_V    = OCC_W'(HI_WM);
  localparam logic [OCC_W-1:0] LO_V    = OCC_W'(LO_WM);

  arb_state_e       state, state_next;
  logic [IDX_W-1:0] ptr, ptr_next, gnt_idx;
  logic [OCC_W-1:0] occ_next;
  logic             grant_en, any_gnt, pop_ok;

  // Shadow occupancy gates grants so push never loops through the FIFO's own flags.
  assign grant_en = !rst && (state == OPEN) && (occ < DEPTH_V);

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_rr_arbiter (
    .req     (req),
    .enable  (grant_en),
    .ptr     (ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign any_gnt     = |gnt;
  assign fifo_push   = any_gnt;
  assign fifo_datain = any_gnt ? req_data[gnt_idx*WIDTH +: WIDTH] : '0;
  assign pop_ok      = !rst && pop_req && (occ != '0);
  assign pop_ack     = pop_ok;
  assign fifo_pop    = pop_ok;
  assign throttle    = (state == THROTTLE);
  assign ptr_next    = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_comb begin
    occ_next = occ;
    case ({any_gnt, pop_ok})
      2'b10:   occ_next = occ + 1'b1;
      2'b01:   occ_next = occ - 1'b1;
      default: occ_next = occ;
    endcase
  end

  // Hysteresis decisions look at next occupancy so throttle lines up with occ.
  always_comb begin
    state_next = OPEN;
    case (state)
      OPEN:     state_next = (occ_next >= HI_V) ? THROTTLE : OPEN;
      THROTTLE: state_next = (occ_next <= LO_V) ? OPEN : THROTTLE;
      default:  state_next = OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ   <= '0;
      ptr   <= '0;
      state <= OPEN;
    end else begin
      occ   <= occ_next;
      state <= state_next;
      if (any_gnt) begin
        ptr <= ptr_next;
      end
    end
  end

`ifdef FIFO_PUSH_ARB_STATS_EN
  logic [STAT_W-1:0] cnt_q [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_stats
    always_ff @(posedge clk) begin
      if (rst) begin
        cnt_q[i] <= '0;
      end else if (gnt[i] && (cnt_q[i] != '1)) begin
        cnt_q[i] <= cnt_q[i] + 1'b1;
      end
    end
    assign grant_cnt[i*STAT_W +: STAT_W] = cnt_q[i];
  end
`endif

endmodule

// File: doc/fifo_push_arb.md
# fifo_push_arb

Round-robin push arbiter and pop gate for the shared 32-entry FIFO. It merges NREQ producer ports onto the FIFO's single push/datain interface and gates the consumer's pop request against emptiness. A watermark-hysteresis throttle FSM pauses producers when the FIFO nears full. Occupancy is tracked in a registered shadow counter, so push never depends combinationally on the FIFO's own count/full outputs, which themselves depend on push.

## Interface
- NREQ, 4 — number of producer ports (2..8)
- WIDTH, 8 — data width
- DEPTH, 32 — FIFO depth
- LOG2DEPTH, 5 — log2(DEPTH)
- HI_WM, 28 — occupancy at which throttling starts (LO_WM < HI_WM ≤ DEPTH)
- LO_WM, 4 — occupancy at which throttling ends
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req  in  NREQ  per-producer push request; held until granted
- req_data  in  NREQ*WIDTH  producer data; slice i = bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, combinational
- pop_req  in  1  consumer pop request
- pop_ack  out  1  pop accepted this cycle
- fifo_push  out  1  to FIFO push
- fifo_pop  out  1  to FIFO pop
- fifo_datain  out  WIDTH  to FIFO datain
- occ  out  LOG2DEPTH+1  shadow occupancy, registered
- throttle  out  1  FSM is in THROTTLE
- grant_cnt  out  NREQ*16  per-port grant counters (only with stats macro)

## Operation
- Grant is allowed when state == OPEN and occ < DEPTH. Otherwise gnt = 0.
- Round-robin: a priority pointer ptr (reset 0) selects the first active req at or after ptr, wrapping modulo NREQ. After a grant to port i, ptr ← (i+1) mod NREQ. ptr is unchanged when nothing is granted.
- At most one gnt bit is set per cycle. fifo_push = |gnt. fifo_datain = the req_data slice of the granted port, or 0 when there is no grant.
- fifo_pop = pop_ack = pop_req & (occ != 0). A pop is never issued on empty, even if a push happens in the same cycle.
- occ_next = occ + fifo_push − fifo_pop. Push and pop in the same cycle leave occ unchanged. occ never exceeds DEPTH and never underflows.
- FSM states:
  - OPEN: go to THROTTLE when occ_next ≥ HI_WM.
  - THROTTLE: go to OPEN when occ_next ≤ LO_WM.
  - There are no other states. Any illegal encoding recovers to OPEN.
- A producer whose req drops before being granted is simply skipped. No request is latched inside this block.

## Timing
- Reset values: occ = 0, ptr = 0, state = OPEN, throttle = 0, grant_cnt = 0. gnt, fifo_push, fifo_pop, pop_ack and fifo_datain are 0 during rst regardless of inputs.
- gnt, fifo_push, fifo_pop and pop_ack respond in the same cycle as their requests; the data transfer happens at that clk edge.
- occ, ptr, state and throttle update at the edge where the transfer occurs. throttle asserts in the first cycle with occ ≥ HI_WM, so that cycle issues no grant.
- Reset asserted mid-operation clears all state at the next edge. Pending requests are not remembered. The FIFO must be reset in the same cycle to keep occ consistent.

## Configuration
- FIFO_PUSH_ARB_STATS_EN defined: each port gets a 16-bit grant counter that increments on that port's grant and saturates at 0xFFFF. grant_cnt carries all counters.
- FIFO_PUSH_ARB_STATS_EN undefined: the counters and the grant_cnt port are absent. Arbitration behaviour is identical.

## Structure
- Package fifo_arb_pkg: throttle state enum (OPEN, THROTTLE), STAT_W = 16, and a default-depth constant shared with the FIFO.
- Sub-module rr_arbiter: req[NREQ], enable, ptr → one-hot gnt plus granted index. Purely combinational. The pointer register stays in the top block.

## Test plan
- Single port 0 requests 5 cycles with pop_req=0 → gnt[0] each cycle, data 0x10..0x14 pushed in order, occ = 5.
- All 4 ports requesting continuously from reset → grant order 0,1,2,3,0,…, each port granted once per 4 cycles.
- Fill to 28 with no pop → throttle=1 and gnt=0 at occ=28. Pop down → throttle stays 1 through occ=5 and clears when occ reaches 4. Grants resume the next cycle.
- occ=0, push and pop_req in the same cycle → pop_ack=0, fifo_pop=0, occ=1. Next cycle pop_req → pop_ack=1, and dataout matches the pushed value.
- occ=10, simultaneous grant and pop_ack → occ stays 10, and FIFO count matches occ every cycle (scoreboard).
- rst asserted at occ=17 during throttle → next cycle occ=0, throttle=0, ptr=0. With stats enabled, grant_cnt = 0.
